flappy_collision_score: RTL

// Consumer end of the pipe/coin X-coordinate generator. Each cycle it reads the in-scope pipe and coin

---
 rtl/flappy_collision_score.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/flappy_collision_score.sv
// Collision, score and game-state controller: tests the in-scope pipe/coin boxes against the fixed
// bird box, raises stop on a crash, and keeps BCD score, coin count and high score.
module flappy_collision_score #(
   parameter int BIRD_X_L   = 200,
   parameter int BIRD_X_R   = 229,
   parameter int CEIL_Y     = 0,
   parameter int FLOOR_Y    = 479,
   parameter int HIT_FILTER = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ack,
   input  logic [9:0]  bird_y_top,
   input  logic [9:0]  bird_y_bot,
   input  logic [2:0]  pipe_idx,
   input  logic [9:0]  pipe_x_l,
   input  logic [9:0]  pipe_x_r,
   input  logic [9:0]  gap_y_top,
   input  logic [9:0]  gap_y_bot,
   input  logic [2:0]  coin_idx,
   input  logic [9:0]  coin_x_l,
   input  logic [9:0]  coin_x_r,
   input  logic [9:0]  coin_y_top,
   input  logic [9:0]  coin_y_bot,
   output logic        stop,
   output logic        coin_hit,
   output logic [11:0] score,
   output logic [7:0]  coins,
   output logic [11:0] high_score,
   output logic        q_idle,
   output logic        q_run,
   output logic        q_done
);

   // state  | meaning
   // IDLE   | waiting for start; score, coins and filter held clear
   // RUN    | game in progress; collision, score and coin tracking active
   // DONE   | crashed; stop asserted, counters frozen until ack
   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_RUN  = 3'b010;
   localparam logic [2:0] S_DONE = 3'b100;

   localparam logic [9:0] BXL     = 10'(BIRD_X_L);
   localparam logic [9:0] BXR     = 10'(BIRD_X_R);
   localparam logic [9:0] CEIL    = 10'(CEIL_Y);
   localparam logic [9:0] FLOOR   = 10'(FLOOR_Y);
   localparam logic [3:0] HIT_LIM = 4'(HIT_FILTER);

   logic [2:0] state, state_nxt;
   logic [3:0] cnt, cnt_inc, cnt_nxt;
   logic [2:0] prev_pipe, prev_coin;
   logic       collected, collected_eff;
   logic       x_ovl, y_bad, pipe_hit, pipe_crash, bound_crash, crash;
   logic       coin_ovl, coin_take;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] h, t, o;
      h = v[11:8];
      t = v[7:4];
      o = v[3:0];
      if (v == 12'h999) return v;
      if (o == 4'd9) begin
         o = 4'd0;
         if (t == 4'd9) begin
            t = 4'd0;
            h = h + 4'd1;
         end else begin
            t = t + 4'd1;
         end
      end else begin
         o = o + 4'd1;
      end
      return {h, t, o};
   endfunction

   always_comb begin
      x_ovl       = (pipe_x_l <= BXR) && (pipe_x_r >= BXL);
      y_bad       = (bird_y_top < gap_y_top) || (bird_y_bot > gap_y_bot);
      pipe_hit    = x_ovl && y_bad;
      cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
      cnt_nxt     = pipe_hit ? cnt_inc : 4'd0;
      pipe_crash  = pipe_hit && (cnt_inc >= HIT_LIM);
      bound_crash = (bird_y_top <= CEIL) || (bird_y_bot >= FLOOR);
      crash       = pipe_crash || bound_crash;
      coin_ovl    = (coin_x_l <= BXR) && (coin_x_r >= BXL) &&
                    (coin_y_top <= bird_y_bot) && (coin_y_bot >= bird_y_top);
      // A new coin index re-arms collection in the same cycle it appears.
      collected_eff = (coin_idx != prev_coin) ? 1'b0 : collected;
      coin_take     = coin_ovl && !collected_eff;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
         S_RUN:   state_nxt = crash ? S_DONE : S_RUN;
         S_DONE:  state_nxt = ack ? S_IDLE : S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      q_idle = (state == S_IDLE);
      q_run  = (state == S_RUN);
      q_done = (state == S_DONE);
      stop   = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score      <= 12'h000;
         coins      <= 8'd0;
         high_score <= 12'h000;
         coin_hit   <= 1'b0;
         cnt        <= 4'd0;
         prev_pipe  <= 3'd0;
         prev_coin  <= 3'd0;
         collected  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               score     <= 12'h000;
               coins     <= 8'd0;
               cnt       <= 4'd0;
               coin_hit  <= 1'b0;
               prev_pipe <= pipe_idx;
               prev_coin <= coin_idx;
               collected <= 1'b0;
            end
            S_RUN: begin
               cnt       <= cnt_nxt;
               prev_pipe <= pipe_idx;
               prev_coin <= coin_idx;
               // A crash on the same cycle as a pipe change does not score that pipe.
               if (!crash && (pipe_idx != prev_pipe)) score <= bcd_inc(score);
               if (coin_take) begin
                  if (coins != 8'hFF) coins <= coins + 8'd1;
                  coin_hit  <= 1'b1;
                  collected <= 1'b1;
               end else begin
                  coin_hit  <= 1'b0;
                  collected <= collected_eff;
               end
            end
            S_DONE: begin
               coin_hit <= 1'b0;
               cnt      <= 4'd0;
               // BCD digits order the same as the raw 12-bit value.
               if (score > high_score) high_score <= score;
            end
            default: begin
               coin_hit <= 1'b0;
               cnt      <= 4'd0;
            end
         endcase
      end
   end

endmodule
